// File: rtl/s2p_tx_arb.sv
// s2p_tx_arb: arbitrates byte send requests and serializes the winner MSB-first onto wra_n/da.
// Define S2P_ARB_FIXED_PRIO_EN for fixed lowest-index-wins arbitration (default: round-robin).
module s2p_tx_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned GAP   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] data,
  output logic [N_REQ-1:0]    ack,
  output logic                wra_n,
  output logic                da,
  output logic                busy
);

  localparam int unsigned CW = $clog2((DW > GAP) ? DW : GAP);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       sreg_q, sreg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                wra_n_q, wra_n_d;
  logic                da_q, da_d;
  logic                busy_q, busy_d;

  logic [N_REQ-1:0]    gnt;
  logic                found;
  logic [DW-1:0]       win_data;
  logic                grant_ok;

`ifndef S2P_ARB_FIXED_PRIO_EN
  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [PW-1:0]       ptr_q, ptr_d, ptr_win;
`endif

  // Winner selection; evaluated every cycle but only consumed when grant_ok is set.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
`ifdef S2P_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
`else
    // Search above the last grant first, then wrap to the low indices.
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i] && (i > int'(ptr_q))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i] && (i <= int'(ptr_q))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    ptr_win = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) ptr_win = PW'(i);
    end
`endif
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) win_data = win_data | data[i*DW +: DW];
    end
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    wra_n_d  = wra_n_q;
    da_d     = da_q;
    busy_d   = busy_q;
    grant_ok = 1'b0;
`ifndef S2P_ARB_FIXED_PRIO_EN
    ptr_d    = ptr_q;
`endif
    unique case (state_q)
      StIdle: grant_ok = |req;
      StShift: begin
        if (cnt_q == '0) begin
          wra_n_d = 1'b1;
          da_d    = 1'b0;
          cnt_d   = CW'(GAP - 1);
          state_d = StGap;
        end else begin
          da_d    = sreg_q[DW-2];
          sreg_d  = sreg_q << 1;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d  = StIdle;
          busy_d   = 1'b0;
          grant_ok = |req;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (grant_ok) begin
      sreg_d  = win_data;
      ack_d   = gnt;
      wra_n_d = 1'b0;
      da_d    = win_data[DW-1];
      cnt_d   = CW'(DW - 1);
      busy_d  = 1'b1;
      state_d = StShift;
`ifndef S2P_ARB_FIXED_PRIO_EN
      ptr_d   = ptr_win;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      wra_n_q <= 1'b1;
      da_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifndef S2P_ARB_FIXED_PRIO_EN
      ptr_q   <= PW'(N_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      wra_n_q <= wra_n_d;
      da_q    <= da_d;
      busy_q  <= busy_d;
`ifndef S2P_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign ack   = ack_q;
  assign wra_n = wra_n_q;
  assign da    = da_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_s2p_tx_arb.sv
// tb_s2p_tx_arb: directed self-checking bench for s2p_tx_arb; outputs sampled on the falling edge.
module tb_s2p_tx_arb;

  localparam int N_REQ  = 4;
  localparam int DW     = 8;
  localparam int GAP    = 4;
  localparam int PERIOD = DW + GAP;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] data;
  logic [N_REQ-1:0]    ack;
  logic                wra_n;
  logic                da;
  logic                busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  s2p_tx_arb #(
    .N_REQ (N_REQ),
    .DW    (DW),
    .GAP   (GAP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .data  (data),
    .ack   (ack),
    .wra_n (wra_n),
    .da    (da),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Observes one frame; optionally drops req on ack and applies a req edit at low-cycle ev_at.
  // Returns at the first falling edge after wra_n rises again (first GAP cycle).
  task automatic wait_frame(input bit drop_on_ack, input int ev_at,
                            input logic [N_REQ-1:0] set_m, input logic [N_REQ-1:0] clr_m,
                            output bit ok, output int start, output logic [N_REQ-1:0] first_ack,
                            output logic [DW-1:0] bits, output int len, output int extra);
    int t;
    ok = 1'b0; start = 0; first_ack = '0; bits = '0; len = 0; extra = 0; t = 0;
    @(negedge clk);
    while (wra_n !== 1'b0 && t < 60) begin
      if (ack !== '0) extra++;
      @(negedge clk);
      t++;
    end
    if (wra_n !== 1'b0) return;
    start     = cyc;
    first_ack = ack;
    while (wra_n === 1'b0 && len < 20) begin
      bits = {bits[DW-2:0], da};
      if (len > 0 && ack !== '0) extra++;
      if (len == 0 && drop_on_ack) req = req & ~ack;
      if (len == ev_at) req = (req | set_m) & ~clr_m;
      len++;
      @(negedge clk);
    end
    if (ack !== '0) extra++;
    ok = (len < 20);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = '0;
    data = '0;
    repeat (2) @(negedge clk);
    checks++; if (wra_n !== 1'b1) begin errors++; $display("FAIL reset_wra_n: got %b want 1", wra_n); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL reset_da: got %b want 0", da); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wra_n !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_hold: got wra_n=%b busy=%b want 1 0", wra_n, busy);
    end
  endtask

  task automatic test_single_frame();
    bit ok; int st, len, ex; logic [N_REQ-1:0] fa; logic [DW-1:0] b;
    do_reset();
    data[1*DW +: DW] = 8'hA5;
    req = 4'b0010;
    wait_frame(1'b1, -1, '0, '0, ok, st, fa, b, len, ex);
    checks++; if (!ok) begin errors++; $display("FAIL single_start: got none want frame"); return; end
    checks++; if (fa !== 4'b0010) begin errors++; $display("FAIL single_ack: got %b want 0010", fa); end
    checks++; if (b !== 8'hA5) begin errors++; $display("FAIL single_bits: got %h want a5", b); end
    checks++; if (len != DW) begin errors++; $display("FAIL single_len: got %0d want %0d", len, DW); end
    checks++; if (ex != 0) begin errors++; $display("FAIL single_extra_ack: got %0d want 0", ex); end
    // Now in the first GAP cycle; three more follow, then idle.
    for (int g = 0; g < GAP; g++) begin
      checks++;
      if (busy !== 1'b1 || wra_n !== 1'b1 || da !== 1'b0) begin
        errors++;
        $display("FAIL single_gap%0d: got busy=%b wra_n=%b da=%b want 1 1 0", g, busy, wra_n, da);
      end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    bit ok; int st, prev, len, ex; logic [N_REQ-1:0] fa; logic [DW-1:0] b, eb;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    req  = 4'b1111;
    prev = 0;
    for (int f = 0; f < 5; f++) begin
      wait_frame(1'b0, -1, '0, '0, ok, st, fa, b, len, ex);
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_start%0d: got none want frame", f); return; end
      eb = 8'(8'h11 * (exp_order[f] + 1));
      checks++;
      if (fa !== 4'(1 << exp_order[f])) begin
        errors++; $display("FAIL rr_ack%0d: got %b want %b", f, fa, 4'(1 << exp_order[f]));
      end
      checks++; if (b !== eb) begin errors++; $display("FAIL rr_bits%0d: got %h want %h", f, b, eb); end
      checks++; if (ex != 0) begin errors++; $display("FAIL rr_extra%0d: got %0d want 0", f, ex); end
      if (f > 0) begin
        checks++;
        if (st - prev != PERIOD) begin
          errors++; $display("FAIL rr_period%0d: got %0d want %0d", f, st - prev, PERIOD);
        end
      end
      prev = st;
    end
    req = '0;
  endtask

  task automatic test_late_request();
    bit ok; int st0, st1, len, ex; logic [N_REQ-1:0] fa; logic [DW-1:0] b;
    do_reset();
    data[0*DW +: DW] = 8'h5A;
    data[2*DW +: DW] = 8'hC3;
    req = 4'b0001;
    wait_frame(1'b1, 3, 4'b0100, '0, ok, st0, fa, b, len, ex);
    checks++; if (!ok) begin errors++; $display("FAIL late_start0: got none want frame"); return; end
    checks++; if (fa !== 4'b0001) begin errors++; $display("FAIL late_ack0: got %b want 0001", fa); end
    checks++; if (b !== 8'h5A) begin errors++; $display("FAIL late_bits0: got %h want 5a", b); end
    checks++; if (ex != 0) begin errors++; $display("FAIL late_extra0: got %0d want 0", ex); end
    wait_frame(1'b1, -1, '0, '0, ok, st1, fa, b, len, ex);
    checks++; if (!ok) begin errors++; $display("FAIL late_start1: got none want frame"); return; end
    checks++; if (fa !== 4'b0100) begin errors++; $display("FAIL late_ack1: got %b want 0100", fa); end
    checks++; if (b !== 8'hC3) begin errors++; $display("FAIL late_bits1: got %h want c3", b); end
    checks++;
    if (st1 - st0 != PERIOD) begin
      errors++; $display("FAIL late_period: got %0d want %0d", st1 - st0, PERIOD);
    end
  endtask

  task automatic test_drop_mid();
    bit ok; int st, len, ex, stray; logic [N_REQ-1:0] fa; logic [DW-1:0] b;
    do_reset();
    data[3*DW +: DW] = 8'h96;
    req = 4'b1000;
    wait_frame(1'b0, 2, '0, 4'b1000, ok, st, fa, b, len, ex);
    checks++; if (!ok) begin errors++; $display("FAIL drop_start: got none want frame"); return; end
    checks++; if (fa !== 4'b1000) begin errors++; $display("FAIL drop_ack: got %b want 1000", fa); end
    checks++; if (b !== 8'h96) begin errors++; $display("FAIL drop_bits: got %h want 96", b); end
    checks++; if (len != DW) begin errors++; $display("FAIL drop_len: got %0d want %0d", len, DW); end
    checks++; if (ex != 0) begin errors++; $display("FAIL drop_extra: got %0d want 0", ex); end
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (wra_n !== 1'b1 || ack !== '0) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL drop_quiet: got %0d want 0", stray); end
  endtask

  task automatic test_reset_mid();
    bit ok; int t, st, len, ex; logic [N_REQ-1:0] fa; logic [DW-1:0] b;
    do_reset();
    data[0*DW +: DW] = 8'h0F;
    data[3*DW +: DW] = 8'hF0;
    req = 4'b1001;
    t = 0;
    @(negedge clk);
    while (wra_n !== 1'b0 && t < 20) begin @(negedge clk); t++; end
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL rmid_ack: got %b want 0001", ack); end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (wra_n !== 1'b1 || da !== 1'b0 || busy !== 1'b0 || ack !== '0) begin
      errors++;
      $display("FAIL rmid_async: got wra_n=%b da=%b busy=%b ack=%b want 1 0 0 0000",
               wra_n, da, busy, ack);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_frame(1'b0, -1, '0, '0, ok, st, fa, b, len, ex);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_start: got none want frame"); return; end
    checks++; if (fa !== 4'b0001) begin errors++; $display("FAIL rmid_first: got %b want 0001", fa); end
    checks++; if (b !== 8'h0F) begin errors++; $display("FAIL rmid_bits: got %h want 0f", b); end
    req = '0;
  endtask

  task automatic test_prio_hold();
    bit ok; int st, len, ex; logic [N_REQ-1:0] fa, ea; logic [DW-1:0] b, eb;
    do_reset();
    data[0*DW +: DW] = 8'h3C;
    data[2*DW +: DW] = 8'hE7;
    req = 4'b0101;
    for (int f = 0; f < 3; f++) begin
      wait_frame(1'b0, -1, '0, '0, ok, st, fa, b, len, ex);
      checks++;
      if (!ok) begin errors++; $display("FAIL prio_start%0d: got none want frame", f); return; end
`ifdef S2P_ARB_FIXED_PRIO_EN
      ea = 4'b0001;
`else
      ea = (f == 1) ? 4'b0100 : 4'b0001;
`endif
      eb = (ea == 4'b0001) ? 8'h3C : 8'hE7;
      checks++; if (fa !== ea) begin errors++; $display("FAIL prio_ack%0d: got %b want %b", f, fa, ea); end
      checks++; if (b !== eb) begin errors++; $display("FAIL prio_bits%0d: got %h want %h", f, b, eb); end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_late_request();
    test_drop_mid();
    test_reset_mid();
    test_prio_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
